fsm_serializer: RTL and testbench



---
 rtl/fsm_serializer_pkg.sv | 29 ++
 rtl/fsm_serializer_if.sv | 30 +++
 rtl/fsm_serializer.sv | 96 +++++++++
 tb/tb_fsm_serializer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial stage feeding the sequence detector.
// Holds the FSM state enum, the length-field width helper and the s_len legality/clamp check.
package fsm_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Result of checking an offered length: clamped value plus illegal flag.
  typedef struct packed {
    logic        illegal;
    logic [15:0] len;
  } len_chk_t;

  // Width of a field able to hold 0..width.
  function automatic int unsigned len_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  // Zero is illegal and stays zero (word gets dropped); above width is illegal and clamps to width.
  function automatic len_chk_t clamp_len(input int unsigned len, input int unsigned width);
    len_chk_t r;
    r.illegal = (len == 0) || (len > width);
    r.len     = (len > width) ? 16'(width) : 16'(len);
    return r;
  endfunction

endpackage

// File: rtl/fsm_serializer_if.sv
// Word-in / bit-out bundle between a word producer and fsm_serializer.
interface fsm_serializer_if
  import fsm_ser_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned LW = len_w(WIDTH);

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic [LW-1:0]    s_len;
  logic             abort;
  logic             ser_out;
  logic             ser_active;
  logic             word_done;
  logic             len_err;
  logic             busy;

  modport master (
    output s_valid, s_data, s_len, abort,
    input  s_ready, ser_out, ser_active, word_done, len_err, busy
  );

  modport slave (
    input  s_valid, s_data, s_len, abort,
    output s_ready, ser_out, ser_active, word_done, len_err, busy
  );

endinterface

// File: rtl/fsm_serializer.sv
// Parallel-to-serial stage: one-entry pending register plus shifter, one bit per clk on ser_out.
// MSB_FIRST sends s_data[WIDTH-1] downward for len bits; otherwise s_data[0] upward.
module fsm_serializer
  import fsm_ser_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input logic             clk,
  input logic             rst,
  fsm_serializer_if.slave s
);

  localparam int unsigned LW = len_w(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [LW-1:0]    r_bits_left;
  logic [WIDTH-1:0] r_pend_data;
  logic [LW-1:0]    r_pend_len;
  logic             r_pend_vld;
  logic             r_len_err;

  logic             w_last;
  logic             w_load_now;
  logic             w_ready;
  logic             w_accept;
  len_chk_t         w_chk;
  logic [LW-1:0]    w_len;

  assign w_last     = (r_state == SHIFT) && (r_bits_left == LW'(1));
  assign w_load_now = r_pend_vld && ((r_state == IDLE) || w_last);
  assign w_ready    = (!r_pend_vld || w_load_now) && !s.abort;
  assign w_accept   = s.s_valid && w_ready;
  assign w_chk      = clamp_len(32'(s.s_len), WIDTH);
  assign w_len      = LW'(w_chk.len);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: abort wins, then a load keeps/enters SHIFT, else the last bit drops to IDLE
  always_comb begin
    w_state_nxt = r_state;
    if (s.abort)         w_state_nxt = IDLE;
    else if (w_load_now) w_state_nxt = SHIFT;
    else if (w_last)     w_state_nxt = IDLE;
  end

  // Shifter, pending slot and len_err pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg     <= '0;
      r_bits_left <= '0;
      r_pend_data <= '0;
      r_pend_len  <= '0;
      r_pend_vld  <= 1'b0;
      r_len_err   <= 1'b0;
    end else if (s.abort) begin
      r_bits_left <= '0;
      r_pend_vld  <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      r_len_err <= w_accept && w_chk.illegal;

      if (w_load_now) begin
        r_shreg     <= r_pend_data;
        r_bits_left <= r_pend_len;
      end else if (r_state == SHIFT) begin
        r_shreg     <= MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};
        r_bits_left <= r_bits_left - LW'(1);
      end

      // A same-edge accept refills the slot that the load is emptying
      if (w_accept && (w_len != '0)) begin
        r_pend_data <= s.s_data;
        r_pend_len  <= w_len;
        r_pend_vld  <= 1'b1;
      end else if (w_load_now) begin
        r_pend_vld  <= 1'b0;
      end
    end
  end

  assign s.s_ready    = w_ready;
  assign s.ser_out    = (r_state == SHIFT) ? (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0]) : IDLE_BIT;
  assign s.ser_active = (r_state == SHIFT);
  assign s.word_done  = w_last;
  assign s.len_err    = r_len_err;
  assign s.busy       = (r_state == SHIFT) || r_pend_vld;

endmodule

// File: tb/tb_fsm_serializer.sv
// Bench for fsm_serializer: MSB-first and LSB-first instances share one stimulus stream.
module tb_fsm_serializer;
  import fsm_ser_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned LW = len_w(W);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          d_valid = 1'b0;
  logic          d_abort = 1'b0;
  logic [W-1:0]  d_data  = '0;
  logic [LW-1:0] d_len   = '0;

  fsm_serializer_if #(.WIDTH(W)) if_m ();
  fsm_serializer_if #(.WIDTH(W)) if_l ();

  assign if_m.s_valid = d_valid;
  assign if_m.s_data  = d_data;
  assign if_m.s_len   = d_len;
  assign if_m.abort   = d_abort;
  assign if_l.s_valid = d_valid;
  assign if_l.s_data  = d_data;
  assign if_l.s_len   = d_len;
  assign if_l.abort   = d_abort;

  fsm_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (.clk(clk), .rst(rst), .s(if_m));
  fsm_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (.clk(clk), .rst(rst), .s(if_l));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {s_ready, ser_out, ser_active, word_done, len_err, busy}
  function automatic logic [5:0] obs(input bit lsb);
    if (lsb) return {if_l.s_ready, if_l.ser_out, if_l.ser_active, if_l.word_done, if_l.len_err, if_l.busy};
    return {if_m.s_ready, if_m.ser_out, if_m.ser_active, if_m.word_done, if_m.len_err, if_m.busy};
  endfunction

  // Single-word vectors: bits holds the expected serial stream, first bit at index 0
  typedef struct {
    logic [7:0]  data;
    logic [3:0]  len;
    bit          lsb;
    logic [15:0] bits;
    int          n;
    bit          err;
  } vec_t;

  vec_t tbl [9];

  task automatic send_word(input vec_t v, input string name);
    logic [15:0] got;
    logic [5:0]  o;
    int n, first, dn, le, bz;
    got = '0; n = 0; first = -1; dn = 0; le = 0; bz = 0;
    d_valid = 1'b1; d_data = v.data; d_len = LW'(v.len);
    tick();
    d_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      o = obs(v.lsb);
      if (o[3]) begin
        if (first < 0) first = k;
        if (n < 16) got[n] = o[4];
        n++;
      end
      dn += int'(o[2]);
      le += int'(o[1]);
      bz += int'(o[0]);
      tick();
    end
    chk({name, "_nbits"}, 32'(n), 32'(v.n));
    chk({name, "_bits"}, 32'(got), 32'(v.bits));
    chk({name, "_word_done"}, 32'(dn), (v.n > 0) ? 32'd1 : 32'd0);
    chk({name, "_len_err"}, 32'(le), 32'(v.err));
    chk({name, "_busy_cycles"}, 32'(bz), (v.n > 0) ? 32'(v.n + 1) : 32'd0);
    if (v.n > 0) chk({name, "_latency"}, 32'(first), 32'd2);
  endtask

  // Reference model: bit queues for the shifting word and the pending word
  bit cur_m[$];
  bit cur_l[$];
  bit pend_m[$];
  bit pend_l[$];
  bit pend_v;
  bit m_lerr;

  function automatic bit m_ready();
    return !d_abort && (!pend_v || cur_m.size() <= 1);
  endfunction

  function automatic logic [5:0] m_obs(input bit lsb);
    bit act, b;
    act = cur_m.size() > 0;
    b   = act ? (lsb ? cur_l[0] : cur_m[0]) : 1'b0;
    return {m_ready(), b, act, cur_m.size() == 1, m_lerr, act || pend_v};
  endfunction

  task automatic model_edge();
    bit acc, load;
    int l;
    acc = d_valid && m_ready();
    l   = int'(d_len);
    if (d_abort) begin
      cur_m.delete(); cur_l.delete(); pend_m.delete(); pend_l.delete();
      pend_v = 1'b0;
      m_lerr = 1'b0;
    end else begin
      m_lerr = acc && (l == 0 || l > int'(W));
      load   = pend_v && cur_m.size() <= 1;
      if (cur_m.size() > 0) begin
        void'(cur_m.pop_front());
        void'(cur_l.pop_front());
      end
      if (load) begin
        cur_m  = pend_m;
        cur_l  = pend_l;
        pend_v = 1'b0;
      end
      if (acc && l != 0) begin
        if (l > int'(W)) l = int'(W);
        pend_m.delete(); pend_l.delete();
        for (int i = 0; i < l; i++) begin
          pend_m.push_back(d_data[int'(W) - 1 - i]);
          pend_l.push_back(d_data[i]);
        end
        pend_v = 1'b1;
      end
    end
  endtask

  initial begin
    logic [5:0]  o;
    logic [15:0] got;
    logic [7:0]  wd [3];
    logic [3:0]  wl [3];
    vec_t        vc;
    int idx, n, first, last, dn, act_cnt, r;

    tbl[0] = '{8'hE5, 4'd8,  1'b0, 16'h00A7, 8, 1'b0};
    tbl[1] = '{8'hFF, 4'd0,  1'b0, 16'h0000, 0, 1'b1};
    tbl[2] = '{8'h81, 4'd12, 1'b0, 16'h0081, 8, 1'b1};
    tbl[3] = '{8'hC0, 4'd2,  1'b0, 16'h0003, 2, 1'b0};
    tbl[4] = '{8'h3C, 4'd5,  1'b0, 16'h001C, 5, 1'b0};
    tbl[5] = '{8'h01, 4'd3,  1'b1, 16'h0001, 3, 1'b0};
    tbl[6] = '{8'h07, 4'd3,  1'b1, 16'h0007, 3, 1'b0};
    tbl[7] = '{8'hA5, 4'd5,  1'b1, 16'h0005, 5, 1'b0};
    tbl[8] = '{8'h3C, 4'd15, 1'b1, 16'h003C, 8, 1'b1};

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk("reset_msb", 32'(obs(1'b0)), 32'h20);
    chk("reset_lsb", 32'(obs(1'b1)), 32'h20);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) send_word(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back words with s_valid held: no idle gap between them
    wd[0] = 8'hFF; wl[0] = 4'd2;
    wd[1] = 8'h00; wl[1] = 4'd1;
    wd[2] = 8'hAA; wl[2] = 4'd3;
    idx = 0; n = 0; first = -1; last = -1; dn = 0; got = '0;
    for (int c = 0; c < 30; c++) begin
      if (idx < 3) begin
        d_valid = 1'b1; d_data = wd[idx]; d_len = LW'(wl[idx]);
      end else begin
        d_valid = 1'b0;
      end
      #1;
      r = int'(if_m.s_ready);
      tick();
      if (idx < 3 && r != 0) idx++;
      o = obs(1'b0);
      if (o[3]) begin
        if (first < 0) first = c;
        last = c;
        if (n < 16) got[n] = o[4];
        n++;
      end
      dn += int'(o[2]);
    end
    d_valid = 1'b0;
    chk("b2b_accepted", 32'(idx), 32'd3);
    chk("b2b_nbits", 32'(n), 32'd6);
    chk("b2b_bits", 32'(got), 32'h002B);
    chk("b2b_no_gap", 32'(last - first + 1), 32'd6);
    chk("b2b_word_done", 32'(dn), 32'd3);

    // Abort on the 3rd bit with a word pending
    d_valid = 1'b1; d_data = 8'hE5; d_len = LW'(8);
    tick();
    d_data = 8'h3C;
    tick();
    d_valid = 1'b0;
    tick(); tick();
    chk("abort_pre_active", 32'(if_m.ser_active), 32'd1);
    chk("abort_pre_busy", 32'(if_m.busy), 32'd1);
    d_abort = 1'b1;
    #1;
    chk("abort_ready_low", 32'(if_m.s_ready), 32'd0);
    tick();
    chk("abort_post", 32'({if_m.ser_out, if_m.ser_active, if_m.busy}), 32'd0);
    d_abort = 1'b0;
    #1;
    chk("abort_ready_back", 32'(if_m.s_ready), 32'd1);
    act_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      act_cnt += int'(if_m.ser_active);
    end
    chk("abort_pending_dropped", 32'(act_cnt), 32'd0);

    // Asynchronous reset mid-word, then normal operation resumes
    d_valid = 1'b1; d_data = 8'hE5; d_len = LW'(8);
    tick();
    d_valid = 1'b0;
    tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_word", 32'({if_m.ser_out, if_m.ser_active, if_m.busy}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    vc = '{8'hC0, 4'd2, 1'b0, 16'h0003, 2, 1'b0};
    send_word(vc, "after_rst");

    // Randomized run against the queue model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cur_m.delete(); cur_l.delete(); pend_m.delete(); pend_l.delete();
    pend_v = 1'b0; m_lerr = 1'b0;
    d_valid = 1'b0; d_abort = 1'b0;
    #1;
    for (int c = 0; c < 1500; c++) begin
      if (obs(1'b0) !== m_obs(1'b0)) chk($sformatf("rand_msb_c%0d", c), 32'(obs(1'b0)), 32'(m_obs(1'b0)));
      else total++;
      if (obs(1'b1) !== m_obs(1'b1)) chk($sformatf("rand_lsb_c%0d", c), 32'(obs(1'b1)), 32'(m_obs(1'b1)));
      else total++;
      @(posedge clk);
      model_edge();
      #1;
      d_valid = ($urandom_range(0, 3) != 0);
      d_data  = W'($urandom);
      r       = int'($urandom_range(0, 15));
      d_len   = (r < 13) ? LW'($urandom_range(1, 8)) : LW'($urandom_range(0, 15));
      d_abort = ($urandom_range(0, 39) == 0);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
